// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter that feeds one PISO serializer, tracks its busy window and enforces an idle gap.
// Define PISO_TX_ARB_STATS_EN for the completed-frame counter and a sticky protocol-error flag.
module piso_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  localparam int IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         ser_data_in,
  output logic                          ser_valid_in,
  input  logic                          ser_busy,
  output logic                          grant_valid,
  output logic [IdW-1:0]                grant_id,
  output logic                          proto_err,
  output logic [15:0]                   frame_cnt
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE, GAP} state_t;

  localparam logic [7:0] GapLoad = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t                state, state_nxt;
  logic [IdW-1:0]        rr_ptr;
  logic [IdW-1:0]        winner;
  logic [IdW-1:0]        winner_inc;
  logic                  found;
  logic                  grant;
  logic                  frame_done;
  logic                  err_evt;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] win_word;
  logic [7:0]            gap_cnt;

  // Search upward from rr_ptr with an explicit wrap so non-power-of-2 counts work.
  always_comb begin : arb_search
    logic [IdW:0]   idx;
    logic [IdW-1:0] sel;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (IdW+1)'(i);
      if (idx >= (IdW+1)'(NUM_REQ)) idx = idx - (IdW+1)'(NUM_REQ);
      sel = idx[IdW-1:0];
      if (!found && req_valid[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IdW'(i)) win_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign winner_inc = (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + IdW'(1);

  // A still-draining serializer blocks new grants even in IDLE.
  assign grant = (state == IDLE) && !ser_busy && found;

  always_comb begin
    state_nxt    = state;
    frame_done   = 1'b0;
    err_evt      = 1'b0;
    req_ready    = '0;
    ser_valid_in = 1'b0;
    grant_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          if (rst_n) req_ready = NUM_REQ'(1) << winner;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        ser_valid_in = 1'b1;
        grant_valid  = 1'b1;
        state_nxt    = WAIT_START;
      end
      WAIT_START: begin
        grant_valid = 1'b1;
        if (ser_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          err_evt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        grant_valid = 1'b1;
        if (!ser_busy) begin
          frame_done = 1'b1;
          state_nxt  = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold     <= '0;
      grant_id <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        hold     <= win_word;
        grant_id <= winner;
        rr_ptr   <= winner_inc;
      end
      if (frame_done) gap_cnt <= GapLoad;
      else if (state == GAP && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
    end
  end

  assign ser_data_in = hold;

`ifdef PISO_TX_ARB_STATS_EN
  logic [15:0] frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (frame_done) frame_q <= frame_q + 16'd1;
      if (err_evt) proto_err <= 1'b1;
    end
  end

  assign frame_cnt = frame_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err <= 1'b0;
    else        proto_err <= err_evt;
  end

  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: a 4-requester instance with a 2-cycle gap and a 3-requester zero-gap instance.
module tb_piso_tx_arbiter;

`ifdef PISO_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  ser_data_in;
  logic        ser_valid_in;
  logic        ser_busy = 1'b0;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        proto_err;
  logic [15:0] frame_cnt;

  logic [2:0]  g0_req_valid;
  logic [23:0] g0_req_data;
  logic [2:0]  g0_req_ready;
  logic [7:0]  g0_ser_data_in;
  logic        g0_ser_valid_in;
  logic        g0_ser_busy = 1'b0;
  logic        g0_grant_valid;
  logic [1:0]  g0_grant_id;
  logic        g0_proto_err;
  logic [15:0] g0_frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_len = 8;
  int busy_left = 0;
  int g0_busy_left = 0;
  bit model_en = 1'b1;
  int exp_frames = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  piso_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ser_data_in(ser_data_in), .ser_valid_in(ser_valid_in), .ser_busy(ser_busy),
    .grant_valid(grant_valid), .grant_id(grant_id), .proto_err(proto_err), .frame_cnt(frame_cnt)
  );

  piso_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .req_valid(g0_req_valid), .req_data(g0_req_data), .req_ready(g0_req_ready),
    .ser_data_in(g0_ser_data_in), .ser_valid_in(g0_ser_valid_in), .ser_busy(g0_ser_busy),
    .grant_valid(g0_grant_valid), .grant_id(g0_grant_id), .proto_err(g0_proto_err), .frame_cnt(g0_frame_cnt)
  );

  // Serializer models: busy starts the cycle after the launch strobe and ignore rst_n.
  always @(posedge clk) begin
    if (ser_valid_in && model_en) begin
      ser_busy  <= 1'b1;
      busy_left <= busy_len - 1;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end else begin
      ser_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (g0_ser_valid_in) begin
      g0_ser_busy  <= 1'b1;
      g0_busy_left <= 2;
    end else if (g0_busy_left != 0) begin
      g0_busy_left <= g0_busy_left - 1;
    end else begin
      g0_ser_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word(input int i, input int k);
    return 8'((i << 4) | (k + 5));
  endfunction

  function automatic logic [15:0] exp_fc(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  always @(negedge clk) begin
    if (req_ready != 4'b0) check("onehot", $countones(req_ready), 1);
    if (ser_valid_in) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_launch", ser_valid_in, 0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_data", ser_data_in, e.dat);
        check("sb_grant_id", grant_id, e.id);
      end
    end
  end

  task automatic wait_rdy(output int idx);
    idx = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      #1;
      if (req_ready != 4'b0) break;
    end
    check("rdy_timeout", req_ready != 4'b0, 1);
    for (int i = 3; i >= 0; i--) if (req_ready[i]) idx = i;
  endtask

  task automatic wait_quiet();
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!grant_valid && !ser_busy) break;
    end
    check("quiet_timeout", t < 300, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int k_cnt[4];
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    g0_req_valid = '0;
    g0_req_data = '0;
    foreach (k_cnt[i]) k_cnt[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_ser_valid", ser_valid_in, 0);
    check("rst_ser_data", ser_data_in, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;

    // Single request on lane 2, then a lane-0 request posted during the gap.
    @(negedge clk);
    req_valid = 4'b0100;
    req_data[16 +: 8] = 8'hA5;
    sb_q.push_back('{id: 2'd2, dat: 8'hA5});
    #1 check("single_rdy", req_ready, 4'b0100);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = '0;
        check("single_launch", ser_valid_in, 1);
        check("single_gid", grant_id, 2);
      end
      if (k == 10) check("single_gv_at_m", grant_valid, 1);
      if (k == 11) begin
        check("single_gv_gap", grant_valid, 0);
        check("single_frame_cnt", frame_cnt, exp_fc(1));
        req_valid = 4'b0001;
        req_data[0 +: 8] = 8'h3C;
        sb_q.push_back('{id: 2'd0, dat: 8'h3C});
      end
      #1;
      if (k == 11 || k == 12) check("gap_hold_rdy", req_ready, 0);
      if (k == 13) check("idle_at_m3_rdy", req_ready, 4'b0001);
    end
    @(negedge clk);
    req_valid = '0;
    wait_quiet();
    exp_frames = 2;

    // Protocol error: serializer never asserts busy.
    model_en = 1'b0;
    @(negedge clk);
    req_valid = 4'b0010;
    req_data[8 +: 8] = 8'h5A;
    sb_q.push_back('{id: 2'd1, dat: 8'h5A});
    #1 check("perr_rdy", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("perr_before", proto_err, 0);
    @(negedge clk);
    check("perr_set", proto_err, 1);
    check("perr_idle_gv", grant_valid, 0);
    check("perr_frame_cnt", frame_cnt, exp_fc(exp_frames));
    @(negedge clk);
    check("perr_after", proto_err, STATS ? 1 : 0);
    model_en = 1'b1;

    // Reset during WAIT_DONE while every requester is waiting.
    busy_len = 20;
    @(negedge clk);
    req_valid = 4'b1000;
    req_data[24 +: 8] = 8'hC3;
    sb_q.push_back('{id: 2'd3, dat: 8'hC3});
    #1 check("mid_rst_rdy", req_ready, 4'b1000);
    @(negedge clk);
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = word(i, 0);
    req_valid = 4'b1111;
    repeat (4) @(negedge clk);
    check("mid_rst_gv_before", grant_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_ser_valid", ser_valid_in, 0);
    check("mid_rst_ser_data", ser_data_in, 0);
    check("mid_rst_grant_valid", grant_valid, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_proto_err", proto_err, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    exp_frames = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_len = 3;
    for (int f = 0; f < 5; f++) sb_q.push_back('{id: 2'(f % 4), dat: word(f % 4, f / 4)});
    #1 check("drain_hold_rdy", req_ready, 0);

    // Round-robin with all four requesters held active.
    for (int f = 0; f < 5; f++) begin
      wait_rdy(idx);
      check("rr_order", idx, f % 4);
      @(posedge clk);
      #1;
      k_cnt[idx]++;
      if (f == 4) req_valid = '0;
      else req_data[idx*8 +: 8] = word(idx, k_cnt[idx]);
      exp_frames++;
    end
    wait_quiet();
    check("rr_frame_cnt", frame_cnt, exp_fc(exp_frames));
    check("sb_drain", sb_q.size(), 0);

    // Zero gap on the 3-requester instance, including the pointer wrap 2 -> 0.
    @(negedge clk);
    g0_req_data = {8'h22, 8'h33, 8'h11};
    g0_req_valid = 3'b101;
    #1 check("g0_first_rdy", g0_req_ready, 3'b001);
    @(negedge clk);
    g0_req_valid = 3'b100;
    check("g0_launch_vld", g0_ser_valid_in, 1);
    check("g0_launch_dat", g0_ser_data_in, 8'h11);
    repeat (4) @(negedge clk);
    check("g0_m_gv", g0_grant_valid, 1);
    #1 check("g0_m_rdy", g0_req_ready, 0);
    @(negedge clk);
    #1 check("g0_zero_gap_rdy", g0_req_ready, 3'b100);
    @(negedge clk);
    g0_req_valid = 3'b011;
    check("g0_second_dat", g0_ser_data_in, 8'h22);
    check("g0_second_gid", g0_grant_id, 2);
    repeat (5) @(negedge clk);
    #1 check("g0_wrap_rdy", g0_req_ready, 3'b001);
    @(negedge clk);
    g0_req_valid = '0;
    repeat (10) @(negedge clk);
    check("g0_frame_cnt", g0_frame_cnt, exp_fc(3));
    check("g0_proto_err", g0_proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
